// File: rtl/mux2_64bit_arb.sv
// mux2_64bit_arb: round-robin 2:1 arbiter feeding one registered 64-bit output.
// Define MUX2_64BIT_ARB_BURST_EN to let a requester hold the grant for BURST_LEN beats.
module mux2_64bit_arb #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        w0_valid,
  input  logic [63:0] w0,
  output logic        w0_ready,
  input  logic        w1_valid,
  input  logic [63:0] w1,
  output logic        w1_ready,
  output logic        f_valid,
  output logic [63:0] f,
  output logic        f_src,
  input  logic        f_ready,
  output logic        s
);

  logic        last_q, last_d;
  logic        fv_q, fv_d;
  logic        fsrc_q, fsrc_d;
  logic [63:0] f_q, f_d;
  logic        sel;
  logic        hold;
  logic        load_ok;
  logic        acc;

  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_chk
    $error("BURST_LEN must be 1..15");
  end

`ifdef MUX2_64BIT_ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d;

  // zero count means no burst in flight, so reset contention goes to 0
  assign hold = (cnt_q != 4'd0) && (cnt_q < 4'(BURST_LEN));

  always_comb begin
    cnt_d = cnt_q;
    if (acc) begin
      if (sel == last_q)
        cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
      else
        cnt_d = 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 4'd0;
    else        cnt_q <= cnt_d;
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    sel = last_q;
    unique case (1'b1)
      w0_valid && !w1_valid: sel = 1'b0;
      !w0_valid && w1_valid: sel = 1'b1;
      w0_valid && w1_valid:  sel = hold ? last_q : !last_q;
      default:               sel = last_q;
    endcase
  end

  assign load_ok  = !fv_q || f_ready;
  assign w0_ready = rst_n && load_ok && !sel && w0_valid;
  assign w1_ready = rst_n && load_ok && sel && w1_valid;
  assign acc      = w0_ready || w1_ready;

  always_comb begin
    last_d = last_q;
    fv_d   = fv_q;
    fsrc_d = fsrc_q;
    f_d    = f_q;
    if (acc) begin
      f_d    = sel ? w1 : w0;
      fsrc_d = sel;
      fv_d   = 1'b1;
      last_d = sel;
    end else if (f_ready) begin
      fv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
      fv_q   <= 1'b0;
      fsrc_q <= 1'b0;
      f_q    <= 64'h0;
    end else begin
      last_q <= last_d;
      fv_q   <= fv_d;
      fsrc_q <= fsrc_d;
      f_q    <= f_d;
    end
  end

  assign f_valid = fv_q;
  assign f       = f_q;
  assign f_src   = fsrc_q;
  assign s       = sel;

endmodule

// File: tb/tb_mux2_64bit_arb.sv
// tb_mux2_64bit_arb: directed and random checks of mux2_64bit_arb
// against a beat-level reference model.
module tb_mux2_64bit_arb;

  localparam int BL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        w0_valid = 1'b0;
  logic        w1_valid = 1'b0;
  logic [63:0] w0 = 64'h0;
  logic [63:0] w1 = 64'h0;
  logic        f_ready = 1'b0;
  logic        w0_ready, w1_ready;
  logic        f_valid, f_src, s;
  logic [63:0] f;

  int n_cmp = 0;
  int n_bad = 0;

  bit          m_fv, m_src, m_last, m_a0, m_a1;
  logic [63:0] m_f;
  int          m_cnt;

  mux2_64bit_arb #(.BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n),
    .w0_valid(w0_valid), .w0(w0), .w0_ready(w0_ready),
    .w1_valid(w1_valid), .w1(w1), .w1_ready(w1_ready),
    .f_valid(f_valid), .f(f), .f_src(f_src),
    .f_ready(f_ready), .s(s)
  );

  always #5 clk = ~clk;

  function automatic bit exp_s();
    if (w0_valid && !w1_valid) return 1'b0;
    if (w1_valid && !w0_valid) return 1'b1;
    if (!w0_valid) return m_last;
`ifdef MUX2_64BIT_ARB_BURST_EN
    if (m_cnt > 0 && m_cnt < BL) return m_last;
`endif
    return !m_last;
  endfunction

  function automatic bit exp_r(bit n);
    bit v;
    v = n ? w1_valid : w0_valid;
    return rst_n && (!m_fv || f_ready) && (exp_s() == n) && v;
  endfunction

  task automatic model_reset();
    m_fv = 0; m_f = 64'h0; m_src = 0;
    m_last = 1; m_cnt = 0; m_a0 = 0; m_a1 = 0;
  endtask

  task automatic model_edge();
    bit n;
    m_a0 = exp_r(1'b0);
    m_a1 = exp_r(1'b1);
    if (m_a0 || m_a1) begin
      n = m_a1;
      if (n == m_last) m_cnt = (m_cnt < 15) ? m_cnt + 1 : m_cnt;
      else m_cnt = 1;
      m_f = n ? w1 : w0;
      m_src = n;
      m_fv = 1;
      m_last = n;
    end else if (f_ready) begin
      m_fv = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1 model_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    w0_valid = 1'b1;
    #1;
    n_cmp++;
    if ({f_valid, f_src, f, w0_ready, w1_ready} !== 67'h0) begin
      n_bad++;
      $display("FAIL reset_init: fv=%b src=%b f=%h r=%b%b need all 0",
               f_valid, f_src, f, w0_ready, w1_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    w0 = {$urandom, $urandom};
    f_ready = 1'b0;
    tick();
    n_cmp++;
    if ({f_valid, f_src, f} !== {m_fv, m_src, m_f} || !f_valid) begin
      n_bad++;
      $display("FAIL reset_preload: fv=%b f=%h need fv=%b f=%h",
               f_valid, f, m_fv, m_f);
    end
    rst_n = 1'b0;
    #1 model_reset();
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({f_valid, f_src, f, w0_ready, w1_ready} !== 67'h0) begin
        n_bad++;
        $display("FAIL reset_hold%0d: fv=%b src=%b f=%h r=%b%b need all 0",
                 i, f_valid, f_src, f, w0_ready, w1_ready);
      end
      tick();
    end
    rst_n = 1'b1;
    w1_valid = 1'b1;
    w1 = {$urandom, $urandom};
    f_ready = 1'b1;
    #1;
    n_cmp++;
    if ({s, w0_ready, w1_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL reset_first_grant: s/r0/r1=%b%b%b need 010",
               s, w0_ready, w1_ready);
    end
    tick();
    n_cmp++;
    if ({f_valid, f_src, f} !== {1'b1, 1'b0, w0}) begin
      n_bad++;
      $display("FAIL reset_first_word: fv=%b src=%b f=%h need 1 0 %h",
               f_valid, f_src, f, w0);
    end
  endtask

  task automatic test_single();
    logic [63:0] base;
    base = 64'hDEAD_BEEF_0000_0001;
    w1_valid = 1'b0;
    w0_valid = 1'b1;
    w0 = base;
    f_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n_cmp++;
      if ({s, w0_ready, w1_ready} !== {exp_s(), exp_r(0), exp_r(1)} || s) begin
        n_bad++;
        $display("FAIL single_grant%0d: s/r0/r1=%b%b%b need %b%b%b",
                 i, s, w0_ready, w1_ready, exp_s(), exp_r(0), exp_r(1));
      end
      tick();
      n_cmp++;
      if ({f_valid, f_src, f} !== {1'b1, 1'b0, base + 64'(i)}) begin
        n_bad++;
        $display("FAIL single_word%0d: fv=%b src=%b f=%h need 1 0 %h",
                 i, f_valid, f_src, f, base + 64'(i));
      end
      if (m_a0) w0 = w0 + 64'd1;
    end
  endtask

  task automatic test_contention();
    bit prev;
    w0 = 64'hAAAA_AAAA_AAAA_AAAA;
    w1 = 64'h5555_5555_5555_5555;
    w0_valid = 1'b1;
    w1_valid = 1'b1;
    f_ready = 1'b1;
    prev = m_src;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_cmp++;
      if ({s, w0_ready, w1_ready} !== {exp_s(), exp_r(0), exp_r(1)}
          || (w0_ready && w1_ready)) begin
        n_bad++;
        $display("FAIL contend_grant%0d: s/r0/r1=%b%b%b need %b%b%b",
                 i, s, w0_ready, w1_ready, exp_s(), exp_r(0), exp_r(1));
      end
      tick();
      n_cmp++;
      if ({f_valid, f_src, f} !== {m_fv, m_src, m_f}
          || f !== (f_src ? w1 : w0)) begin
        n_bad++;
        $display("FAIL contend_word%0d: fv=%b src=%b f=%h need %b %b %h",
                 i, f_valid, f_src, f, m_fv, m_src, m_f);
      end
`ifndef MUX2_64BIT_ARB_BURST_EN
      n_cmp++;
      if (f_src === prev) begin
        n_bad++;
        $display("FAIL contend_alt%0d: src=%b repeated, need %b",
                 i, f_src, !prev);
      end
`endif
      prev = f_src;
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    w1_valid = 1'b0;
    w0_valid = 1'b1;
    w0 = {$urandom, $urandom};
    f_ready = 1'b0;
    tick();
    held = m_f;
    w0 = {$urandom, $urandom};
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({w0_ready, w1_ready} !== 2'b00 || {f_valid, f} !== {1'b1, held}) begin
        n_bad++;
        $display("FAIL bp_stall%0d: r=%b%b fv=%b f=%h need r=00 fv=1 f=%h",
                 i, w0_ready, w1_ready, f_valid, f, held);
      end
      tick();
    end
    f_ready = 1'b1;
    #1;
    n_cmp++;
    if ({s, w0_ready, w1_ready} !== 3'b010) begin
      n_bad++;
      $display("FAIL bp_release: s/r0/r1=%b%b%b need 010",
               s, w0_ready, w1_ready);
    end
    tick();
    n_cmp++;
    if ({f_valid, f_src, f} !== {1'b1, 1'b0, w0}) begin
      n_bad++;
      $display("FAIL bp_reload: fv=%b src=%b f=%h need 1 0 %h",
               f_valid, f_src, f, w0);
    end
  endtask

  task automatic test_drain();
    w0_valid = 1'b0;
    w1_valid = 1'b1;
    w1 = 64'hFFFF_FFFF_FFFF_FFFF;
    f_ready = 1'b1;
    tick();
    n_cmp++;
    if ({f_valid, f_src, f} !== {1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
      n_bad++;
      $display("FAIL drain_load: fv=%b src=%b f=%h need 1 1 ffff..",
               f_valid, f_src, f);
    end
    w1_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if ({s, w0_ready, w1_ready} !== 3'b100) begin
        n_bad++;
        $display("FAIL drain_sel%0d: s/r0/r1=%b%b%b need 100",
                 i, s, w0_ready, w1_ready);
      end
      tick();
      n_cmp++;
      if ({f_valid, f_src, f} !== {1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF}) begin
        n_bad++;
        $display("FAIL drain_idle%0d: fv=%b src=%b f=%h need 0 1 ffff..",
                 i, f_valid, f_src, f);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if (!(w0_valid && !m_a0) || $urandom_range(15) == 0) begin
        w0_valid = ($urandom_range(3) != 0);
        w0 = {$urandom, $urandom};
      end
      if (!(w1_valid && !m_a1) || $urandom_range(15) == 0) begin
        w1_valid = ($urandom_range(3) != 0);
        w1 = {$urandom, $urandom};
      end
      f_ready = ($urandom_range(3) != 0);
      #1;
      n_cmp++;
      if ({s, w0_ready, w1_ready} !== {exp_s(), exp_r(0), exp_r(1)}) begin
        n_bad++;
        $display("FAIL rand_grant%0d: s/r0/r1=%b%b%b need %b%b%b",
                 i, s, w0_ready, w1_ready, exp_s(), exp_r(0), exp_r(1));
      end
      tick();
      n_cmp++;
      if ({f_valid, f_src, f} !== {m_fv, m_src, m_f}) begin
        n_bad++;
        $display("FAIL rand_word%0d: fv=%b src=%b f=%h need %b %b %h",
                 i, f_valid, f_src, f, m_fv, m_src, m_f);
      end
    end
  endtask

`ifdef MUX2_64BIT_ARB_BURST_EN
  task automatic test_burst();
    bit exp_src [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    w0_valid = 1'b0;
    w1_valid = 1'b0;
    pulse_reset();
    w0 = 64'hAAAA_AAAA_AAAA_AAAA;
    w1 = 64'h5555_5555_5555_5555;
    w0_valid = 1'b1;
    w1_valid = 1'b1;
    f_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_cmp++;
      if ({f_valid, f_src} !== {1'b1, exp_src[i]} || f_src !== m_src) begin
        n_bad++;
        $display("FAIL burst_seq%0d: fv=%b src=%b need 1 %b",
                 i, f_valid, f_src, exp_src[i]);
      end
    end
    w0_valid = 1'b0;
    w1_valid = 1'b0;
    pulse_reset();
    w0_valid = 1'b1;
    w1_valid = 1'b1;
    tick();
    tick();
    w0_valid = 1'b0;
    #1;
    n_cmp++;
    if ({s, w0_ready, w1_ready} !== 3'b101) begin
      n_bad++;
      $display("FAIL burst_handoff: s/r0/r1=%b%b%b need 101",
               s, w0_ready, w1_ready);
    end
    tick();
    n_cmp++;
    if ({f_valid, f_src, f} !== {1'b1, 1'b1, w1}) begin
      n_bad++;
      $display("FAIL burst_handoff_word: fv=%b src=%b f=%h need 1 1 %h",
               f_valid, f_src, f, w1);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drain();
    test_random();
`ifdef MUX2_64BIT_ARB_BURST_EN
    test_burst();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux2_64bit_arb.md
# mux2_64bit_arb

Two-requester arbiter and scheduler for the 64-bit 2:1 select datapath. It accepts 64-bit words from two independent valid/ready sources and drives the select of a 2:1 mux. The selected word lands in a single output register with a valid/ready handshake. It sits in front of any consumer that shares one 64-bit bus between two producers. Arbitration is round-robin, with optional burst holding.

## Interface
- BURST_LEN, 4, max consecutive beats granted to one requester (used only with burst feature; legal 1..15)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- w0_valid  input  1  requester 0 has a word
- w0  input  64  requester 0 data
- w0_ready  output  1  requester 0 word accepted this cycle (with w0_valid)
- w1_valid  input  1  requester 1 has a word
- w1  input  64  requester 1 data
- w1_ready  output  1  requester 1 word accepted this cycle (with w1_valid)
- f_valid  output  1  output register holds a word
- f  output  64  output word
- f_src  output  1  source index of word in f
- f_ready  input  1  consumer accepts f this cycle
- s  output  1  current mux select (combinational grant)

## Operation
- Datapath: f_next = s ? w1 : w0, captured into the output register on accept.
- Output register can load when `load_ok = !f_valid || f_ready`.
- Grant (combinational):
  - Only one requester valid: that requester wins.
  - Both valid: the requester not equal to `last` wins, where `last` is the index of the most recently accepted word.
  - Neither valid: s holds `last`.
- Ready signals:
  - wN_ready = load_ok && (s == N) && wN_valid.
  - At most one ready is high per cycle; never both.
- Accept (wN_valid && wN_ready) effects:
  - f <= wN, f_src <= N, f_valid <= 1.
  - last <= N.
- Output drain:
  - f_valid && f_ready with no accept in the same cycle: f_valid <= 0.
  - f and f_src hold their values.
- Simultaneous drain and accept: the register reloads and f_valid stays 1, giving full throughput of one word per cycle.
- Reset values:
  - f_valid=0, f=64'h0, f_src=0.
  - last=1, so requester 0 wins the first contention.
  - burst counter=0.
  - w0_ready and w1_ready are 0 while rst_n is low.
- Reset mid-operation: any word in the output register is discarded with no drain.
- Requester rules:
  - A requester must hold valid and data until it sees ready.
  - Dropping valid early is legal and simply forfeits the grant.

## Timing
- Latency: 1 cycle. A word accepted at edge k is on f with f_valid=1 after edge k.
- Throughput: 1 word/cycle while f_ready=1.
- Both requesters valid continuously with f_ready=1: grants alternate 0,1,0,1,...
- Backpressure (f_valid=1, f_ready=0):
  - Both readys are 0.
  - The grant does not advance.
  - Burst counter is unchanged.
- s may change combinationally with wN_valid; consumers of s must not register it as a qualified select without wN_ready.

## Configuration
- Macro: MUX2_64BIT_ARB_BURST_EN.
- Defined (burst holding):
  - If the last accepted requester is still valid and burst count < BURST_LEN, it keeps the grant even if the other requester is valid.
  - The count increments on each accept by the same requester.
  - The count resets to 1 on an accept from the other requester.
  - After BURST_LEN consecutive beats the grant passes to the other requester if it is valid.
  - BURST_LEN=1 is identical to the undefined behaviour.
- Undefined: pure per-beat round-robin as in Operation. BURST_LEN is ignored and no counter is synthesized.

## Test plan
- Reset: assert rst_n=0 mid-stream with f_valid=1, then release -> f_valid=0, f=0, f_src=0, both readys 0 during reset; first contention after release grants requester 0.
- Single source: w0_valid=1 with w0=64'hDEAD_BEEF_0000_0001 incrementing, w1_valid=0, f_ready=1 -> f follows one cycle later, f_src=0 each beat, 1 word/cycle, s=0.
- Contention: both valid continuously, w0=64'hAAAA..., w1=64'h5555..., f_ready=1 -> f_src sequence 0,1,0,1,... and f alternates 64'hAAAA...,64'h5555...; w0_ready/w1_ready never high together.
- Backpressure: f_valid=1, f_ready=0 for 5 cycles -> f stable, both readys 0; on f_ready=1, same-cycle reload with f_valid staying 1.
- Drain: single word from w1=64'hFFFF_FFFF_FFFF_FFFF, then no requests -> f_valid falls the cycle after f_ready; s holds 1.
- Burst (MUX2_64BIT_ARB_BURST_EN, BURST_LEN=4): both valid continuously, f_ready=1 -> f_src 0,0,0,0,1,1,1,1,0,...; w0 dropping valid after 2 beats hands off to w1 immediately.
